// File: rtl/regfile_pkg.sv
// Constants and grant encoding shared by the register-file port controller.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    GNT_WB0 = 1'b0,
    GNT_WB1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not granted last wins.
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_any
);
  import regfile_pkg::*;

  gnt_e last_grant_q;
  gnt_e last_grant_d;

  always_comb begin
    o_grant0     = !i_rst && i_req0 && (!i_req1 || last_grant_q == GNT_WB1);
    o_grant1     = !i_rst && i_req1 && (!i_req0 || last_grant_q == GNT_WB0);
    o_any        = o_grant0 || o_grant1;
    last_grant_d = last_grant_q;
    if (o_grant0) begin
      last_grant_d = GNT_WB0;
    end else if (o_grant1) begin
      last_grant_d = GNT_WB1;
    end
  end

  // Reset to wb1 so the ALU path wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= GNT_WB1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file front end: shared write port arbitration, hardwired r0 and
// same-cycle write-to-read forwarding around a 1-cycle registered read.
module regfile_port_ctrl #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb0_valid,
  input  logic [ADDR_W-1:0] i_wb0_addr,
  input  logic [DATA_W-1:0] i_wb0_data,
  output logic              o_wb0_ready,
  input  logic              i_wb1_valid,
  input  logic [ADDR_W-1:0] i_wb1_addr,
  input  logic [DATA_W-1:0] i_wb1_data,
  output logic              o_wb1_ready,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [ADDR_W-1:0] o_rf_raddr1,
  output logic [ADDR_W-1:0] o_rf_raddr2,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_rf_we,
  input  logic [DATA_W-1:0] i_rf_rdata1,
  input  logic [DATA_W-1:0] i_rf_rdata2,
  output logic [CNT_W-1:0]  o_conflicts
);
  import regfile_pkg::*;

  logic grant0;
  logic grant1;
  logic grant_any;

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req0   (i_wb0_valid),
    .i_req1   (i_wb1_valid),
    .o_grant0 (grant0),
    .o_grant1 (grant1),
    .o_any    (grant_any)
  );

  logic              rd_valid_q, rd_valid_d;
  logic              zero1_q, zero1_d;
  logic              zero2_q, zero2_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;
  logic [DATA_W-1:0] bypdata_q, bypdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    o_wb0_ready = grant0;
    o_wb1_ready = grant1;
    o_rf_waddr  = grant1 ? i_wb1_addr : i_wb0_addr;
    o_rf_wdata  = grant1 ? i_wb1_data : i_wb0_data;
    o_rf_we     = grant_any && (o_rf_waddr != ADDR_W'(ZERO_REG)) && !i_rst;
    o_rf_raddr1 = i_raddr1;
    o_rf_raddr2 = i_raddr2;

    // The register file returns the pre-write value on a same-cycle hit,
    // so remember the in-flight write and substitute it next cycle.
    rd_valid_d = i_rd_valid;
    zero1_d    = (i_raddr1 == ADDR_W'(ZERO_REG));
    zero2_d    = (i_raddr2 == ADDR_W'(ZERO_REG));
    byp1_d     = o_rf_we && (o_rf_waddr == i_raddr1);
    byp2_d     = o_rf_we && (o_rf_waddr == i_raddr2);
    bypdata_d  = o_rf_wdata;

    cnt_d = cnt_q;
    if (i_wb0_valid && i_wb1_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      zero1_q    <= 1'b0;
      zero2_q    <= 1'b0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      bypdata_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      zero1_q    <= zero1_d;
      zero2_q    <= zero2_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      bypdata_q  <= bypdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Data is forced to zero when no read is valid so idle cycles stay deterministic.
  always_comb begin
    o_rd_valid  = rd_valid_q;
    o_conflicts = cnt_q;
    o_rdata1    = '0;
    o_rdata2    = '0;
    if (rd_valid_q) begin
      o_rdata1 = zero1_q ? '0 : (byp1_q ? bypdata_q : i_rf_rdata1);
      o_rdata2 = zero2_q ? '0 : (byp2_q ? bypdata_q : i_rf_rdata2);
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural 32x32 register file.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid, rd_valid;
  logic [4:0]  wb0_addr, wb1_addr, raddr1, raddr2;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, o_rd_valid, rf_we;
  logic [31:0] rdata1, rdata2, rf_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] conflicts;

  // r0 deliberately holds garbage so the hardwired-zero path is exercised.
  logic [31:0] rf_mem [32] = '{0: 32'hBAD0BAD0, default: 32'h0};
  logic [31:0] rf_rdata1 = '0;
  logic [31:0] rf_rdata2 = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    rf_rdata1 <= rf_mem[rf_raddr1];
    rf_rdata2 <= rf_mem[rf_raddr2];
  end

  regfile_port_ctrl #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb0_valid (wb0_valid),
    .i_wb0_addr  (wb0_addr),
    .i_wb0_data  (wb0_data),
    .o_wb0_ready (wb0_ready),
    .i_wb1_valid (wb1_valid),
    .i_wb1_addr  (wb1_addr),
    .i_wb1_data  (wb1_data),
    .o_wb1_ready (wb1_ready),
    .i_rd_valid  (rd_valid),
    .i_raddr1    (raddr1),
    .i_raddr2    (raddr2),
    .o_rd_valid  (o_rd_valid),
    .o_rdata1    (rdata1),
    .o_rdata2    (rdata2),
    .o_rf_raddr1 (rf_raddr1),
    .o_rf_raddr2 (rf_raddr2),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata),
    .o_rf_we     (rf_we),
    .i_rf_rdata1 (rf_rdata1),
    .i_rf_rdata2 (rf_rdata2),
    .o_conflicts (conflicts)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wb0_valid = 1'b0; wb1_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_conflicts", 32'(conflicts), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    rd_valid = 1'b0; raddr1 = '0; raddr2 = '0;

    // Reset holds off grants and writes even with a request pending.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    rd_valid = 1'b1; raddr1 = 5'd5;
    #1;
    check("rst_ready0", 32'(wb0_ready), 32'h0);
    check("rst_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    check("rst_rd_valid", 32'(o_rd_valid), 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_conflicts0", 32'(conflicts), 32'h0);
    rst = 1'b0; rd_valid = 1'b0;
    #1;
    check("t1_ready0", 32'(wb0_ready), 32'h1);
    check("t1_we", 32'(rf_we), 32'h1);
    check("t1_waddr", 32'(rf_waddr), 32'd5);
    check("t1_wdata", rf_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_idle_rd_valid", 32'(o_rd_valid), 32'h0);
    wb0_valid = 1'b0; rd_valid = 1'b1; raddr1 = 5'd5; raddr2 = 5'd0;
    @(negedge clk);
    check("t1_rd_valid", 32'(o_rd_valid), 32'h1);
    check("t1_rdata1", rdata1, 32'hDEADBEEF);
    check("t1_rdata2", rdata2, 32'h0);
    rd_valid = 1'b0;

    // Contention: wb0 wins first after reset, then strict alternation.
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h22;
    #1;
    check("t2a_ready0", 32'(wb0_ready), 32'h1);
    check("t2a_ready1", 32'(wb1_ready), 32'h0);
    check("t2a_waddr", 32'(rf_waddr), 32'd1);
    @(negedge clk);
    check("t2a_conflicts", 32'(conflicts), 32'd1);
    wb0_addr = 5'd3; wb0_data = 32'h33;
    #1;
    check("t2b_ready1", 32'(wb1_ready), 32'h1);
    check("t2b_ready0", 32'(wb0_ready), 32'h0);
    check("t2b_wdata", rf_wdata, 32'h22);
    @(negedge clk);
    check("t2b_conflicts", 32'(conflicts), 32'd2);
    wb1_addr = 5'd4; wb1_data = 32'h44;
    #1;
    check("t2c_ready0", 32'(wb0_ready), 32'h1);
    check("t2c_waddr", 32'(rf_waddr), 32'd3);
    @(negedge clk);
    check("t2c_conflicts", 32'(conflicts), 32'd3);
    wb0_addr = 5'd6; wb0_data = 32'h66;
    #1;
    check("t2d_ready1", 32'(wb1_ready), 32'h1);
    check("t2d_waddr", 32'(rf_waddr), 32'd4);
    @(negedge clk);
    check("t2d_conflicts", 32'(conflicts), 32'd4);
    wb1_valid = 1'b0;
    #1;
    check("t2e_ready0", 32'(wb0_ready), 32'h1);
    check("t2e_waddr", 32'(rf_waddr), 32'd6);
    @(negedge clk);
    check("t2e_conflicts", 32'(conflicts), 32'd4);
    wb0_valid = 1'b0;

    // A write to r0 is accepted but never reaches the register file.
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'hFFFFFFFF;
    #1;
    check("t3_ready1", 32'(wb1_ready), 32'h1);
    check("t3_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    wb1_valid = 1'b0; rd_valid = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
    @(negedge clk);
    check("t3_r0_valid", 32'(o_rd_valid), 32'h1);
    check("t3_r0_rdata1", rdata1, 32'h0);
    check("t3_r0_rdata2", rdata2, 32'h0);
    raddr1 = 5'd2; raddr2 = 5'd4;
    @(negedge clk);
    check("t3_rf_rdata1", rdata1, 32'h22);
    check("t3_rf_rdata2", rdata2, 32'h44);
    rd_valid = 1'b0;

    // Same-cycle forwarding on both ports, then plain register-file reads.
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    @(negedge clk);
    wb0_data = 32'hA5A5A5A5; rd_valid = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("t4_we", 32'(rf_we), 32'h1);
    @(negedge clk);
    check("t4_byp_rdata1", rdata1, 32'hA5A5A5A5);
    check("t4_byp_rdata2", rdata2, 32'hA5A5A5A5);
    wb0_valid = 1'b0; raddr1 = 5'd7; raddr2 = 5'd1;
    @(negedge clk);
    check("t4_next_rdata1", rdata1, 32'hA5A5A5A5);
    check("t4_next_rdata2", rdata2, 32'h11);
    wb0_valid = 1'b1; wb0_data = 32'h5A5A5A5A; raddr1 = 5'd7; raddr2 = 5'd6;
    @(negedge clk);
    check("t4_mix_rdata1", rdata1, 32'h5A5A5A5A);
    check("t4_mix_rdata2", rdata2, 32'h66);
    wb0_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    check("t4_idle_valid", 32'(o_rd_valid), 32'h0);
    check("t4_idle_rdata1", rdata1, 32'h0);

    // Saturation of the contention counter.
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 5'd8; wb0_data = 32'h88;
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99;
    repeat (65534) @(negedge clk);
    check("t5_cnt_fffe", 32'(conflicts), 32'hFFFE);
    @(negedge clk);
    check("t5_cnt_ffff", 32'(conflicts), 32'hFFFF);
    repeat (6) @(negedge clk);
    check("t5_cnt_sat", 32'(conflicts), 32'hFFFF);
    wb0_valid = 1'b0; wb1_valid = 1'b0;

    // Reset squashes an in-flight read; the pending wb1 write is retried.
    @(negedge clk);
    rst = 1'b1; rd_valid = 1'b1; raddr1 = 5'd5;
    wb1_valid = 1'b1; wb1_addr = 5'd10; wb1_data = 32'h1010;
    #1;
    check("t6_rst_ready1", 32'(wb1_ready), 32'h0);
    check("t6_rst_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    check("t6_rd_valid", 32'(o_rd_valid), 32'h0);
    check("t6_rdata1", rdata1, 32'h0);
    check("t6_conflicts", 32'(conflicts), 32'h0);
    rst = 1'b0; rd_valid = 1'b0;
    #1;
    check("t6_ready1", 32'(wb1_ready), 32'h1);
    check("t6_we", 32'(rf_we), 32'h1);
    check("t6_waddr", 32'(rf_waddr), 32'd10);
    @(negedge clk);
    wb1_valid = 1'b0; rd_valid = 1'b1; raddr1 = 5'd10; raddr2 = 5'd5;
    @(negedge clk);
    check("t6_rd_r10", rdata1, 32'h1010);
    check("t6_rd_r5", rdata2, 32'hDEADBEEF);
    rd_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
